// File: rtl/mmio_rr_arbiter_if.sv
// Requester-side and slave-side MMIO signals of the round-robin arbiter.
// The arbiter takes the master modport; the requesters and the peripheral use the slave modport.
interface mmio_rr_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);
  logic [N_REQ-1:0]        s_req;
  logic [N_REQ-1:0]        s_we;
  logic [N_REQ*ADDR_W-1:0] s_addr;
  logic [N_REQ*XLEN-1:0]   s_wdata;
  logic [XLEN-1:0]         s_rdata;
  logic [N_REQ-1:0]        s_ready;
  logic                    s_err;
  logic                    m_req;
  logic                    m_we;
  logic [ADDR_W-1:0]       m_addr;
  logic [XLEN-1:0]         m_wdata;
  logic [XLEN-1:0]         m_rdata;
  logic                    m_ready;

  modport master (
    input  s_req, s_we, s_addr, s_wdata, m_rdata, m_ready,
    output s_rdata, s_ready, s_err, m_req, m_we, m_addr, m_wdata
  );

  modport slave (
    output s_req, s_we, s_addr, s_wdata, m_rdata, m_ready,
    input  s_rdata, s_ready, s_err, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mmio_rr_arbiter.sv
// Round-robin arbiter sharing one MMIO slave port between N_REQ requesters,
// one outstanding transaction, watchdog completes hung transfers with s_err.
module mmio_rr_arbiter #(
  parameter int N_REQ   = 2,
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32,
  parameter int XLEN    = 32
) (
  input logic               clk,
  input logic               rst,
  mmio_rr_arbiter_if.master bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [XLEN-1:0]  ERR_DATA = XLEN'(32'hDEAD_BEEF);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t             r_state;
  logic               r_m_req;
  logic               r_m_we;
  logic [ADDR_W-1:0]  r_m_addr;
  logic [XLEN-1:0]    r_m_wdata;
  logic [IDX_W-1:0]   r_last;
  logic [IDX_W-1:0]   r_grant;
  logic [WD_W-1:0]    r_wdog;

  logic               w_any;
  logic [IDX_W-1:0]   w_pick;
  logic               w_timeout;
  logic               w_done;
  logic [N_REQ-1:0]   w_s_ready;
  logic               w_s_err;
  logic [XLEN-1:0]    w_s_rdata;

  // Scan distances from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_any  = 1'b0;
    w_pick = r_last;
    for (int k = N_REQ; k >= 1; k--) begin
      logic [IDX_W-1:0] cand;
      cand = IDX_W'((int'(r_last) + k) % N_REQ);
      if (bus.s_req[cand]) begin
        w_any  = 1'b1;
        w_pick = cand;
      end
    end
  end

  assign w_timeout = (r_wdog == WD_LAST);
  assign w_done    = (r_state == ST_BUSY) && (bus.m_ready || w_timeout);

  // Completion is reported in the same cycle the slave answers; slave ready beats the watchdog.
  always_comb begin
    w_s_ready = '0;
    w_s_err   = 1'b0;
    w_s_rdata = '0;
    if (w_done) begin
      w_s_ready[r_grant] = 1'b1;
      if (bus.m_ready) begin
        w_s_rdata = bus.m_rdata;
      end else begin
        w_s_err   = 1'b1;
        w_s_rdata = ERR_DATA;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state   <= ST_IDLE;
      r_m_req   <= 1'b0;
      r_m_we    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
      r_grant   <= '0;
      r_wdog    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant   <= w_pick;
            r_m_we    <= bus.s_we[w_pick];
            r_m_addr  <= bus.s_addr[int'(w_pick)*ADDR_W +: ADDR_W];
            r_m_wdata <= bus.s_wdata[int'(w_pick)*XLEN +: XLEN];
            r_m_req   <= 1'b1;
            r_wdog    <= '0;
            r_state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_done) begin
            r_m_req <= 1'b0;
            r_last  <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.m_req   = r_m_req;
  assign bus.m_we    = r_m_we;
  assign bus.m_addr  = r_m_addr;
  assign bus.m_wdata = r_m_wdata;
  assign bus.s_ready = w_s_ready;
  assign bus.s_err   = w_s_err;
  assign bus.s_rdata = w_s_rdata;
endmodule

// File: tb/tb_mmio_rr_arbiter.sv
// Directed bench for mmio_rr_arbiter: requester/slave models plus a completion scoreboard.
module tb_mmio_rr_arbiter;
  localparam int N  = 2;
  localparam int TO = 8;

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          busy;
  } exp_t;

  logic clk;
  logic rst;

  mmio_rr_arbiter_if #(.N_REQ(N), .ADDR_W(32), .XLEN(32)) bus ();

  mmio_rr_arbiter #(.N_REQ(N), .TIMEOUT(TO), .ADDR_W(32), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  exp_t        q[$];
  exp_t        mon_e;
  int          busy_cnt = 0;
  int          req_left[N];
  bit          done_pulse[N];
  int          slave_lat = 0;
  int          s_cnt = 0;
  logic [31:0] mem [logic [31:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester model: hold s_req until the requested number of completions has been seen.
  initial begin
    for (int i = 0; i < N; i++) begin
      req_left[i]   = 0;
      done_pulse[i] = 1'b0;
    end
    bus.s_req = '0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (done_pulse[i]) begin
          done_pulse[i] = 1'b0;
          if (req_left[i] > 0) req_left[i]--;
        end
        bus.s_req[i] = (req_left[i] > 0);
      end
    end
  end

  // Slave model: answers after slave_lat stalled cycles (never when negative), small memory.
  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (rst || !bus.m_req) begin
        s_cnt       = 0;
        bus.m_ready = 1'b0;
        bus.m_rdata = 32'hFFFF_0000;
      end else begin
        if (s_cnt == slave_lat) begin
          bus.m_ready = 1'b1;
          if (bus.m_we) begin
            mem[bus.m_addr] = bus.m_wdata;
            bus.m_rdata     = 32'h0;
          end else begin
            bus.m_rdata = mem.exists(bus.m_addr) ? mem[bus.m_addr] : 32'h0;
          end
        end else begin
          bus.m_ready = 1'b0;
          bus.m_rdata = 32'hFFFF_0000 | 32'(s_cnt);
        end
        s_cnt++;
      end
    end
  end

  // Monitor: checks slave-side fields against the scoreboard head, pops on completion.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
    end else begin
      if (bus.m_req) busy_cnt++;
      check("ready_onehot", 32'($countones(bus.s_ready) <= 1), 32'd1);
      if (bus.m_req) begin
        if (q.size() == 0) begin
          check("spurious_grant", 32'(bus.m_req), 32'd0);
        end else begin
          check("m_addr", bus.m_addr, q[0].addr);
          check("m_we", 32'(bus.m_we), 32'(q[0].we));
          check("m_wdata", bus.m_wdata, q[0].wdata);
        end
      end
      if (bus.s_ready != '0) begin
        if (q.size() == 0) begin
          check("spurious_ready", 32'(bus.s_ready), 32'd0);
        end else begin
          logic [N-1:0] exp_ready;
          mon_e = q.pop_front();
          exp_ready = '0;
          exp_ready[mon_e.port] = 1'b1;
          check("s_ready_port", 32'(bus.s_ready), 32'(exp_ready));
          check("s_err", 32'(bus.s_err), 32'(mon_e.err));
          check("s_rdata", bus.s_rdata, mon_e.rdata);
          check("busy_cycles", 32'(busy_cnt), 32'(mon_e.busy));
        end
        for (int i = 0; i < N; i++) if (bus.s_ready[i]) done_pulse[i] = 1'b1;
        busy_cnt = 0;
      end else begin
        check("idle_s_rdata", bus.s_rdata, 32'h0);
        check("idle_s_err", 32'(bus.s_err), 32'd0);
      end
    end
  end

  task automatic issue(input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input int n);
    bus.s_we[p]            = we;
    bus.s_addr[p*32 +: 32] = a;
    bus.s_wdata[p*32 +: 32] = wd;
    req_left[p]            = n;
  endtask

  task automatic expect_done(input int p, input logic we, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rd,
                             input logic err, input int busy);
    exp_t e;
    e.port = p; e.we = we; e.addr = a; e.wdata = wd;
    e.rdata = rd; e.err = err; e.busy = busy;
    q.push_back(e);
  endtask

  task automatic drain(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = (q.size() == 0) && !bus.m_req && (bus.s_req == '0);
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    rst         = 1'b1;
    bus.s_we    = '0;
    bus.s_addr  = '0;
    bus.s_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_m_req", 32'(bus.m_req), 32'd0);
    check("rst_m_we", 32'(bus.m_we), 32'd0);
    check("rst_m_addr", bus.m_addr, 32'h0);
    check("rst_m_wdata", bus.m_wdata, 32'h0);
    check("rst_s_ready", 32'(bus.s_ready), 32'd0);
    check("rst_s_err", 32'(bus.s_err), 32'd0);
    check("rst_s_rdata", bus.s_rdata, 32'h0);
    #1 rst = 1'b0;

    // Port 0 writes the LED register, port 1 reads it back; m_req one cycle after s_req.
    @(posedge clk); #1;
    slave_lat = 0;
    issue(0, 1'b1, 32'h0000_0010, 32'h0000_A5A5, 1);
    expect_done(0, 1'b1, 32'h0000_0010, 32'h0000_A5A5, 32'h0, 1'b0, 1);
    @(negedge clk);
    check("lat_s_req_seen", 32'(bus.s_req), 32'd1);
    check("lat_m_req_low", 32'(bus.m_req), 32'd0);
    @(negedge clk);
    check("lat_m_req_high", 32'(bus.m_req), 32'd1);
    drain("drain_t1_write");
    @(posedge clk); #1;
    issue(1, 1'b0, 32'h0000_0010, 32'h0, 1);
    expect_done(1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_A5A5, 1'b0, 1);
    drain("drain_t1_read");

    // Both requesters held high: strict alternation starting with port 0.
    @(posedge clk); #1;
    issue(0, 1'b1, 32'h0000_0020, 32'h0000_0011, 3);
    issue(1, 1'b1, 32'h0000_0024, 32'h0000_0022, 3);
    for (int i = 0; i < 3; i++) begin
      expect_done(0, 1'b1, 32'h0000_0020, 32'h0000_0011, 32'h0, 1'b0, 1);
      expect_done(1, 1'b1, 32'h0000_0024, 32'h0000_0022, 32'h0, 1'b0, 1);
    end
    drain("drain_t2_alternate");

    // Slave stalls 5 cycles, answers on the 6th BUSY cycle.
    @(posedge clk); #1;
    slave_lat = 5;
    issue(0, 1'b0, 32'h0000_0020, 32'h0000_0077, 1);
    expect_done(0, 1'b0, 32'h0000_0020, 32'h0000_0077, 32'h0000_0011, 1'b0, 6);
    drain("drain_t3_stall");

    // Slave never answers: error completion on the TIMEOUT-th BUSY cycle, then normal grant.
    @(posedge clk); #1;
    slave_lat = -1;
    issue(1, 1'b1, 32'h0000_0030, 32'h0000_0033, 1);
    expect_done(1, 1'b1, 32'h0000_0030, 32'h0000_0033, 32'hDEAD_BEEF, 1'b1, TO);
    drain("drain_t4_timeout");
    check("t4_no_write", 32'(mem.exists(32'h0000_0030)), 32'd0);
    @(posedge clk); #1;
    slave_lat = 0;
    issue(0, 1'b0, 32'h0000_0024, 32'h0, 1);
    expect_done(0, 1'b0, 32'h0000_0024, 32'h0, 32'h0000_0022, 1'b0, 1);
    drain("drain_t4_after");

    // Slave answers exactly on the timeout cycle: ready wins.
    @(posedge clk); #1;
    slave_lat = TO - 1;
    issue(1, 1'b0, 32'h0000_0010, 32'h0, 1);
    expect_done(1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_A5A5, 1'b0, TO);
    drain("drain_t5_race");
    @(posedge clk); #1;
    slave_lat = 1;
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 1);
    expect_done(0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0011, 1'b0, 2);
    drain("drain_t5_port0");

    // Reset mid-BUSY: m_req drops at once, no completion, pointer back to port 0.
    @(posedge clk); #1;
    slave_lat = -1;
    issue(0, 1'b0, 32'h0000_0040, 32'h0, 1);
    expect_done(0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b1, TO);
    repeat (3) @(negedge clk);
    check("t6_busy_before_rst", 32'(bus.m_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_rst_m_req", 32'(bus.m_req), 32'd0);
    check("t6_rst_s_ready", 32'(bus.s_ready), 32'd0);
    q.delete();
    req_left[0] = 0;
    repeat (2) @(negedge clk);
    check("t6_rst_m_addr", bus.m_addr, 32'h0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    slave_lat = 0;
    issue(0, 1'b0, 32'h0000_0020, 32'h0, 1);
    issue(1, 1'b0, 32'h0000_0010, 32'h0, 1);
    expect_done(0, 1'b0, 32'h0000_0020, 32'h0, 32'h0000_0011, 1'b0, 1);
    expect_done(1, 1'b0, 32'h0000_0010, 32'h0, 32'h0000_A5A5, 1'b0, 1);
    drain("drain_t6_after_rst");

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
